// File: rtl/mux16_arb_pkg.sv
// Shared constants, state encoding and helpers for the 16-channel mux arbiter.
package mux16_arb_pkg;

  localparam int NCH  = 16;
  localparam int IDXW = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // One-hot encoding of a channel index.
  function automatic logic [NCH-1:0] onehot(input logic [IDXW-1:0] idx);
    onehot = {{(NCH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux16_arb_rr_pick16.sv
// Combinational round-robin search: first requester at or after last+1, with wrap.
module rr_pick16
  import mux16_arb_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [IDXW-1:0] last,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] w_cand;

  // Scan the 16 candidates in priority order; the first hit wins.
  always_comb begin
    any    = 1'b0;
    idx    = 4'h0;
    w_cand = 4'h0;
    for (int k = 1; k <= NCH; k++) begin
      w_cand = last + k[IDXW-1:0];
      idx    = (!any && req[w_cand]) ? w_cand : idx;
      any    = any | req[w_cand];
    end
  end

endmodule

// File: rtl/mux16_arb.sv
// 16:1 mux arbiter: round-robin owner selection, bounded hold time,
// registered select / one-hot grant, one idle bubble between grants.
module mux16_arb
  import mux16_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8  // legal 2..255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic            done,
  output logic [IDXW-1:0] sel,
  output logic [NCH-1:0]  gnt,
  output logic            gnt_valid
);

  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  state_t          r_state;
  logic [IDXW-1:0] r_last;
  logic [7:0]      r_cnt;
  logic [IDXW-1:0] r_sel;
  logic [NCH-1:0]  r_gnt;
  logic            r_gnt_valid;

  logic            w_any;
  logic [IDXW-1:0] w_idx;
  logic            w_release;

  rr_pick16 u_pick (
    .req  (req),
    .last (r_last),
    .any  (w_any),
    .idx  (w_idx)
  );

  // r_sel always equals the owner while in GRANT, so it indexes the owner's request.
  assign w_release = done | ~req[r_sel] | (r_cnt == CNT_LAST);

  // Arbiter state, pointer, hold counter and registered mux outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= 4'hF;
      r_cnt       <= 8'd0;
      r_sel       <= 4'h0;
      r_gnt       <= 16'h0000;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_GRANT;
            r_sel       <= w_idx;
            r_gnt       <= onehot(w_idx);
            r_gnt_valid <= 1'b1;
            r_cnt       <= 8'd0;
          end else begin
            // sel is deliberately left alone so the mux path does not move
            r_gnt       <= 16'h0000;
            r_gnt_valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state     <= ST_IDLE;
            r_last      <= r_sel;
            r_gnt       <= 16'h0000;
            r_gnt_valid <= 1'b0;
            r_cnt       <= 8'd0;
          end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt       <= 16'h0000;
          r_gnt_valid <= 1'b0;
          r_cnt       <= 8'd0;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_mux16_arb.sv
// Self-checking bench for mux16_arb: directed scenarios plus randomized
// traffic compared against a behavioural owner/last/held model.
module tb_mux16_arb;

  localparam int HM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        gnt_valid;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_owner;
  int m_last;
  int m_held;
  int m_sel;

  mux16_arb #(.HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] rq, input logic dn);
    @(negedge clk);
    req  = rq;
    done = dn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] oh(input int ch);
    logic [15:0] one;
    one = 16'h0001;
    oh  = one << ch;
  endfunction

  // One clock of the behavioural arbiter: who owns the mux after this edge.
  task automatic model_step(input logic [15:0] rq, input logic dn);
    int pick;
    int c;
    if (m_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= 16; k++) begin
        c = (m_last + k) % 16;
        if (pick < 0 && rq[c]) pick = c;
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_held  = 1;
        m_sel   = pick;
      end
    end else begin
      if (dn || !rq[m_owner] || m_held == HM) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_held = m_held + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 16'hFFFF;
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b0, 4'h0, 16'h0000}) begin
      failures++;
      $display("FAIL reset: v=%0b sel=%0d gnt=%h, expected v=0 sel=0 gnt=0000", gnt_valid, sel, gnt);
    end
    @(negedge clk);
    req = 16'h0000;
    rst = 1'b0;
  endtask

  task automatic test_first_grant();
    drive(16'h0001, 1'b0);
    checks++;
    if (gnt_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_grant_early: v=%0b, expected 0 before edge", gnt_valid);
    end
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
      failures++;
      $display("FAIL first_grant: v=%0b sel=%0d gnt=%h, expected v=1 sel=0 gnt=0001", gnt_valid, sel, gnt);
    end
    drive(16'h0000, 1'b0);
    step();
    checks++;
    if ({gnt_valid, gnt} !== {1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL first_release: v=%0b gnt=%h, expected v=0 gnt=0000", gnt_valid, gnt);
    end
  endtask

  task automatic test_rotation();
    int ch;
    do_reset();
    drive(16'hFFFF, 1'b0);
    for (int r = 0; r < 17; r++) begin
      ch = r % 16;
      for (int c = 0; c < HM; c++) begin
        step();
        checks++;
        if ({gnt_valid, sel, gnt} !== {1'b1, 4'(ch), oh(ch)}) begin
          failures++;
          $display("FAIL rotation_hold: round %0d cyc %0d v=%0b sel=%0d gnt=%h, expected ch %0d", r, c, gnt_valid, sel, gnt, ch);
        end
      end
      step();
      checks++;
      if ({gnt_valid, sel, gnt} !== {1'b0, 4'(ch), 16'h0000}) begin
        failures++;
        $display("FAIL rotation_bubble: round %0d v=%0b sel=%0d gnt=%h, expected v=0 sel=%0d gnt=0000", r, gnt_valid, sel, gnt, ch);
      end
    end
    drive(16'h0000, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    drive(16'h0020, 1'b0);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd5, 16'h0020}) begin
      failures++;
      $display("FAIL wrap_setup: v=%0b sel=%0d gnt=%h, expected ch 5", gnt_valid, sel, gnt);
    end
    drive(16'h0021, 1'b1);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b0, 4'd5, 16'h0000}) begin
      failures++;
      $display("FAIL wrap_release: v=%0b sel=%0d gnt=%h, expected bubble sel=5", gnt_valid, sel, gnt);
    end
    drive(16'h0021, 1'b0);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
      failures++;
      $display("FAIL wrap_grant0: v=%0b sel=%0d gnt=%h, expected ch 0", gnt_valid, sel, gnt);
    end
    drive(16'h0021, 1'b1);
    step();
    drive(16'h0021, 1'b0);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd5, 16'h0020}) begin
      failures++;
      $display("FAIL wrap_grant5: v=%0b sel=%0d gnt=%h, expected ch 5", gnt_valid, sel, gnt);
    end
    drive(16'h0000, 1'b0);
    step();
  endtask

  task automatic test_done();
    // done while idle must not do anything
    drive(16'h0000, 1'b1);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b0, 4'd5, 16'h0000}) begin
      failures++;
      $display("FAIL idle_done: v=%0b sel=%0d gnt=%h, expected v=0 sel=5", gnt_valid, sel, gnt);
    end
    drive(16'h0008, 1'b0);
    step();
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd3, 16'h0008}) begin
      failures++;
      $display("FAIL done_owner3: v=%0b sel=%0d gnt=%h, expected ch 3", gnt_valid, sel, gnt);
    end
    drive(16'h0008, 1'b1);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b0, 4'd3, 16'h0000}) begin
      failures++;
      $display("FAIL done_release: v=%0b sel=%0d gnt=%h, expected v=0 sel=3", gnt_valid, sel, gnt);
    end
    drive(16'h0018, 1'b0);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd4, 16'h0010}) begin
      failures++;
      $display("FAIL done_last3: v=%0b sel=%0d gnt=%h, expected ch 4", gnt_valid, sel, gnt);
    end
  endtask

  task automatic test_drop();
    drive(16'h0000, 1'b0);
    step();
    drive(16'h0080, 1'b0);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd7, 16'h0080}) begin
      failures++;
      $display("FAIL drop_owner7: v=%0b sel=%0d gnt=%h, expected ch 7", gnt_valid, sel, gnt);
    end
    drive(16'h0280, 1'b0);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd7, 16'h0080}) begin
      failures++;
      $display("FAIL drop_other_req: v=%0b sel=%0d gnt=%h, expected ch 7 kept", gnt_valid, sel, gnt);
    end
    drive(16'h0200, 1'b0);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b0, 4'd7, 16'h0000}) begin
      failures++;
      $display("FAIL drop_release: v=%0b sel=%0d gnt=%h, expected bubble sel=7", gnt_valid, sel, gnt);
    end
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd9, 16'h0200}) begin
      failures++;
      $display("FAIL drop_grant9: v=%0b sel=%0d gnt=%h, expected ch 9", gnt_valid, sel, gnt);
    end
  endtask

  task automatic test_async_reset();
    drive(16'h0000, 1'b0);
    step();
    drive(16'h1000, 1'b0);
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd12, 16'h1000}) begin
      failures++;
      $display("FAIL arst_owner12: v=%0b sel=%0d gnt=%h, expected ch 12", gnt_valid, sel, gnt);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt_valid, gnt} !== {1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL arst_async: v=%0b gnt=%h, expected v=0 gnt=0000 without edge", gnt_valid, gnt);
    end
    req = 16'h1001;
    step();
    checks++;
    if (gnt_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_held: v=%0b, expected 0 while rst high", gnt_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if ({gnt_valid, sel, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
      failures++;
      $display("FAIL arst_prio0: v=%0b sel=%0d gnt=%h, expected ch 0", gnt_valid, sel, gnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] rq;
    logic        dn;
    logic [15:0] exp_gnt;
    int          errs;
    do_reset();
    m_owner = -1;
    m_last  = 15;
    m_held  = 0;
    m_sel   = 0;
    rq      = 16'h0000;
    errs    = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rq = 16'h0000;
      dn = ($urandom_range(0, 9) == 0);
      drive(rq, dn);
      step();
      model_step(rq, dn);
      exp_gnt = (m_owner >= 0) ? oh(m_owner) : 16'h0000;
      checks++;
      if ({gnt_valid, sel, gnt} !== {(m_owner >= 0), 4'(m_sel), exp_gnt} ||
          gnt[sel] !== gnt_valid) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random: cyc %0d req=%h done=%0b v=%0b sel=%0d gnt=%h, expected v=%0b sel=%0d gnt=%h",
                   n, rq, dn, gnt_valid, sel, gnt, (m_owner >= 0), m_sel, exp_gnt);
      end
    end
    drive(16'h0000, 1'b0);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    test_reset();
    test_first_grant();
    test_rotation();
    test_wrap();
    test_done();
    test_drop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux16_arb.md
MUX16_ARB -- requirements
Module: mux16_arb

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum number of cycles one grant is held (legal range 2..255).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  16  per-channel request; bit i set means channel i wants the 16:1 mux path.
REQ-005 Port: done  input  1  consumer pulse: current transfer complete.
REQ-006 Port: sel  output  4  mux select; sel[0]=s1, sel[1]=s2, sel[2]=s3, sel[3]=s4 of the 16:1 mux.
REQ-007 Port: gnt  output  16  one-hot grant, all-zero when no owner.
REQ-008 Port: gnt_valid  output  1  high while a channel owns the mux.

Function
REQ-009 The block SHALL have two states, IDLE and GRANT, plus a 4-bit last-owner pointer (last) and a hold counter.
REQ-010 In IDLE with req != 0, the block SHALL pick the first requesting channel searching (last+1) mod 16 upward with wrap, and enter GRANT on the next edge.
REQ-011 In IDLE with req == 0, the block SHALL stay in IDLE with gnt=0, gnt_valid=0, sel unchanged.
REQ-012 Entering GRANT, the block SHALL register sel=owner index, gnt=one-hot(owner), gnt_valid=1, and clear the hold counter; latency from req to gnt_valid is exactly 1 cycle.
REQ-013 In GRANT, the hold counter SHALL increment each cycle, saturating at HOLD_MAX-1.
REQ-014 In GRANT, the block SHALL release when done=1, or req[owner]=0, or the hold counter equals HOLD_MAX-1, whichever comes first.
REQ-015 On release, the block SHALL set last=owner, gnt=0, gnt_valid=0 and return to IDLE for exactly one bubble cycle before any new grant.
REQ-016 sel SHALL hold its last value during IDLE (no glitching of the mux path between grants).
REQ-017 Changes to req bits other than req[owner] during GRANT SHALL NOT affect the current grant.
REQ-018 done while in IDLE SHALL be ignored.
REQ-019 With only one requester continuously active, that channel SHALL be re-granted after each one-cycle bubble.
REQ-020 gnt SHALL always be zero or one-hot, and gnt[sel]=gnt_valid at all times.

Reset
REQ-021 While rst=1, state=IDLE, sel=4'h0, gnt=16'h0000, gnt_valid=0, hold counter=0, last=4'hF (channel 0 has first priority).
REQ-022 Reset asserted mid-GRANT SHALL drop gnt and gnt_valid immediately (asynchronously), without waiting for a clock edge.
REQ-023 The first grant after reset deassertion SHALL occur no earlier than the first rising edge with rst=0.

Structure
REQ-024 A shared package SHALL hold NCH=16, the index width 4, and the IDLE/GRANT state encoding.
REQ-025 The round-robin search SHALL be a combinational sub-module rr_pick16 (inputs req, last; outputs any, idx).
REQ-026 The state, pointer, counter and output registers SHALL reside in mux16_arb only.

Verification
REQ-027 Reset, then req=16'h0001 -> one cycle later gnt=16'h0001, sel=0, gnt_valid=1.
REQ-028 req=16'hFFFF held, done never asserted, HOLD_MAX=8 -> each grant lasts 8 cycles, then 1 bubble cycle; owners 0,1,2,...,15,0 in order.
REQ-029 last=5, req=16'h0021 -> grant channel 0 (wrap past 15), sel=0; next grant channel 5.
REQ-030 Owner 3, done pulse on the 2nd GRANT cycle -> gnt_valid low on the next cycle, last=3.
REQ-031 Owner 7, req[7] dropped while req[9] rises -> release, bubble, then gnt=16'h0200, sel=9.
REQ-032 rst pulsed mid-GRANT (owner 12) -> gnt=0, gnt_valid=0 without a clock edge; after release, req=16'h1001 grants channel 0 first.
